// File: rtl/fp_sqrt_pipe_if.sv
// fp_sqrt_pipe_if: operand/result handshake bundle for fp_sqrt_pipe
// n/tag_in/data_valid_in/ready_out form the operand side, result/tag_out/flag_*/data_valid_out/ready_in
// the result side, busy reports any occupied stage; master drives operands, slave is the square-root unit.
interface fp_sqrt_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
);
  logic [EXP_W+MAN_W:0] n;
  logic [TAG_W-1:0] tag_in;
  logic data_valid_in;
  logic ready_out;
  logic [EXP_W+MAN_W:0] result;
  logic [TAG_W-1:0] tag_out;
  logic flag_invalid;
  logic flag_inexact;
  logic data_valid_out;
  logic ready_in;
  logic busy;
  modport master (
    output n, tag_in, data_valid_in, ready_in,
    input ready_out, result, tag_out, flag_invalid, flag_inexact, data_valid_out, busy
  );
  modport slave (
    input n, tag_in, data_valid_in, ready_in,
    output ready_out, result, tag_out, flag_invalid, flag_inexact, data_valid_out, busy
  );
endinterface

// File: rtl/fp_sqrt_pipe.sv
// fp_sqrt_pipe: pipelined IEEE-754 square root, round-to-nearest-even, specials, valid/ready backpressure
// clk_in, rst (synchronous, active high); io (fp_sqrt_pipe_if.slave): operand n + tag_in + data_valid_in
// with ready_out, result + tag_out + flag_invalid + flag_inexact + data_valid_out with ready_in, busy.
// FP_SQRT_SUBNORMAL_EN: normalise subnormal operands instead of flushing them to signed zero.
module fp_sqrt_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input logic clk_in,
  input logic rst,
  fp_sqrt_pipe_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int S = MAN_W + 2;
  localparam int XW = 2 * S;
  localparam int RW = MAN_W + 6;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  logic en, acc, s, zero, sub, inf, nan, sp_u, inv_u;
  logic [EXP_W-1:0] ex, re;
  logic [MAN_W-1:0] mn;
  logic [MAN_W:0] sig;
  logic signed [EXP_W+1:0] ee;
  logic [W-1:0] spv_u;
  logic [XW-1:0] x_u;
  logic [S:0] v, sp, inv;
  logic [XW-1:0] x [0:S];
  logic [RW-1:0] r [0:S];
  logic [S-1:0] q [0:S];
  logic [EXP_W-1:0] e [0:S];
  logic [TAG_W-1:0] t [0:S];
  logic [W-1:0] spv [0:S];
  logic [RW-1:0] nr [1:S];
  logic [S:1] ng;
  logic [MAN_W:0] rnd;
  logic g, st;
  assign en = !io.data_valid_out || io.ready_in;
  assign io.ready_out = en;
  assign acc = io.data_valid_in && en;
  assign {s, ex, mn} = io.n;
  always_comb begin
    zero = ex == '0 && mn == '0;
    sub = ex == '0 && mn != '0;
    inf = &ex && mn == '0;
    nan = &ex && mn != '0;
    sp_u = 1'b1;
    inv_u = 1'b0;
    spv_u = QNAN;
    if (nan) inv_u = !mn[MAN_W-1];
    else if (zero) spv_u = {s, {(W-1){1'b0}}};
`ifndef FP_SQRT_SUBNORMAL_EN
    else if (sub) spv_u = {s, {(W-1){1'b0}}};
`endif
    else if (s) inv_u = 1'b1;
    else if (inf) spv_u = PINF;
    else sp_u = 1'b0;
  end
`ifdef FP_SQRT_SUBNORMAL_EN
  localparam int LW = $clog2(MAN_W + 2);
  logic [MAN_W:0] sm;
  logic [LW-1:0] lz;
  logic fnd;
  always_comb begin
    sm = {1'b0, mn};
    lz = '0;
    fnd = 1'b0;
    for (int i = MAN_W; i >= 0; i--) begin
      fnd = fnd | sm[i];
      lz = fnd ? lz : lz + LW'(1);
    end
    sig = sub ? sm << lz : {1'b1, mn};
    ee = sub ? (EXP_W+2)'(1 - BIAS) - (EXP_W+2)'(lz) : (EXP_W+2)'(ex) - (EXP_W+2)'(BIAS);
  end
`else
  assign sig = {1'b1, mn};
  assign ee = (EXP_W+2)'(ex) - (EXP_W+2)'(BIAS);
`endif
  // odd exponent: fold one factor of two into the radicand so the halved exponent is exact
  assign re = EXP_W'((ee >>> 1) + (EXP_W+2)'(BIAS));
  assign x_u = {ee[0] ? {sig, 1'b0} : {1'b0, sig}, {S{1'b0}}};
  // one restoring root step per stage, consuming the radicand two bits at a time
  always_comb begin
    logic [RW-1:0] rs, tr;
    ng = '0;
    for (int k = 1; k <= S; k++) begin
      rs = {r[k-1][RW-3:0], x[k-1][XW-1 -: 2]};
      tr = RW'({q[k-1], 2'b01});
      ng[k] = rs >= tr;
      nr[k] = ng[k] ? rs - tr : rs;
    end
  end
  always_ff @(posedge clk_in)
    if (rst) v <= '0;
    else if (en) v <= {v[S-1:0], acc};
  always_ff @(posedge clk_in)
    if (en) begin
      x[0] <= x_u;
      r[0] <= '0;
      q[0] <= '0;
      e[0] <= re;
      t[0] <= io.tag_in;
      spv[0] <= spv_u;
      sp <= {sp[S-1:0], sp_u};
      inv <= {inv[S-1:0], inv_u};
      for (int k = 1; k <= S; k++) begin
        x[k] <= x[k-1] << 2;
        r[k] <= nr[k];
        q[k] <= {q[k-1][S-2:0], ng[k]};
        e[k] <= e[k-1];
        t[k] <= t[k-1];
        spv[k] <= spv[k-1];
      end
    end
  assign g = q[S][0];
  assign st = r[S] != '0;
  // a carry out of the fraction leaves it zero and bumps the exponent
  assign rnd = {1'b0, q[S][S-2:1]} + (MAN_W+1)'(g && (st || q[S][1]));
  always_ff @(posedge clk_in)
    if (rst) begin
      io.data_valid_out <= 1'b0;
      io.result <= '0;
      io.tag_out <= '0;
      io.flag_invalid <= 1'b0;
      io.flag_inexact <= 1'b0;
    end else if (en) begin
      io.data_valid_out <= v[S];
      io.result <= sp[S] ? spv[S] : {1'b0, e[S] + EXP_W'(rnd[MAN_W]), rnd[MAN_W-1:0]};
      io.tag_out <= t[S];
      io.flag_invalid <= v[S] && sp[S] && inv[S];
      io.flag_inexact <= v[S] && !sp[S] && (g || st);
    end
  assign io.busy = |v || io.data_valid_out;
endmodule

// File: tb/tb_fp_sqrt_pipe.sv
// tb_fp_sqrt_pipe: scoreboard bench for fp_sqrt_pipe (binary16 main instance, binary32 smoke instance)
module tb_fp_sqrt_pipe;
  typedef struct {
    logic [15:0] res;
    logic [3:0] tag;
    bit inv, inx, lc;
    int p;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst;
  int ec = 0;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit bp_mode = 0;
  logic [3:0] tag_ctr = '0;
  exp_t sb[$];
  fp_sqrt_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) h ();
  fp_sqrt_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) h32 ();
  fp_sqrt_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (.clk_in(clk_in), .rst(rst), .io(h.slave));
  fp_sqrt_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (.clk_in(clk_in), .rst(rst), .io(h32.slave));
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) ec <= ec + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  // correctly rounded root from the value itself: x = m*2^k, sqrt via integer isqrt on a widened m
  function automatic void ref_sqrt(input int ew, input int mw, input longint unsigned a,
                                   output longint unsigned res, output bit inv, output bit inx);
    longint unsigned sg, ex, mn, emax, qnan, m, lo, hi, mid, rem, y, keep;
    int bias, k, j, sh, ex_r;
    bit g, st;
    sg = (a >> (ew + mw)) & 1;
    ex = (a >> mw) & ((64'd1 << ew) - 1);
    mn = a & ((64'd1 << mw) - 1);
    emax = (64'd1 << ew) - 1;
    qnan = (emax << mw) | (64'd1 << (mw - 1));
    bias = (1 << (ew - 1)) - 1;
    inv = 0;
    inx = 0;
    res = qnan;
    if (ex == emax && mn != 0) begin inv = ((mn >> (mw - 1)) & 1) == 0; return; end
    if (ex == 0 && mn == 0) begin res = sg << (ew + mw); return; end
`ifndef FP_SQRT_SUBNORMAL_EN
    if (ex == 0) begin res = sg << (ew + mw); return; end
`endif
    if (sg == 1) begin inv = 1; return; end
    if (ex == emax) begin res = a; return; end
    m = (ex == 0) ? mn : (mn | (64'd1 << mw));
    k = (ex == 0) ? 1 - bias - mw : int'(ex) - bias - mw;
    if (k % 2 != 0) begin m = m << 1; k = k - 1; end
    j = 0;
    while (m < (64'd1 << 60)) begin m = m << 2; j++; end
    lo = 0;
    hi = 64'd1 << 31;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= m) lo = mid; else hi = mid;
    end
    y = lo;
    rem = m - y * y;
    sh = 30 - mw;
    keep = y >> sh;
    g = ((y >> (sh - 1)) & 1) != 0;
    st = (y & ((64'd1 << (sh - 1)) - 1)) != 0 || rem != 0;
    ex_r = 30 + k / 2 - j + bias;
    if (g && (st || keep[0])) keep++;
    if ((keep >> (mw + 1)) != 0) begin keep = keep >> 1; ex_r++; end
    res = (longint'(ex_r) << mw) | (keep & ((64'd1 << mw) - 1));
    inx = g || st;
  endfunction
  task automatic send(input logic [15:0] op, input bit lc);
    longint unsigned r;
    bit iv, ix, ok;
    exp_t e;
    ref_sqrt(5, 10, 64'(op), r, iv, ix);
    ok = 0;
    while (!ok) begin
      @(negedge clk_in);
      h.n = op;
      h.tag_in = tag_ctr;
      h.data_valid_in = 1'b1;
      #2;
      ok = h.ready_out;
    end
    e.res = r[15:0];
    e.tag = tag_ctr;
    e.inv = iv;
    e.inx = ix;
    e.lc = lc;
    e.p = ec;
    sb.push_back(e);
    tag_ctr++;
  endtask
  task automatic idle();
    @(negedge clk_in);
    h.data_valid_in = 1'b0;
  endtask
  task automatic drain();
    for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk_in);
    chk("drain_leftover", 64'(sb.size()), 64'd0);
  endtask
  function automatic logic [15:0] rnd16();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(1, 0) == 1) x[15] = 1'b0;
    if ($urandom_range(7, 0) == 0) x[14:10] = 5'd0;
    return x;
  endfunction
  initial begin
    h.ready_in = 1'b1;
    forever begin
      @(negedge clk_in);
      h.ready_in = bp_mode ? ((ec % 5) >= 3) : 1'b1;
    end
  end
  initial begin : mon
    exp_t e;
    bit held;
    logic [15:0] hr;
    logic [3:0] ht;
    logic hi, hx;
    held = 0;
    wait (started);
    forever begin
      @(negedge clk_in);
      #3;
      if (rst) begin held = 0; continue; end
      chk("ready_out", 64'(h.ready_out), 64'(!(h.data_valid_out && !h.ready_in)));
      if (held) begin
        chk("stall_valid", 64'(h.data_valid_out), 64'd1);
        chk("stall_result", 64'(h.result), 64'(hr));
        chk("stall_tag", 64'(h.tag_out), 64'(ht));
        chk("stall_flags", 64'({h.flag_invalid, h.flag_inexact}), 64'({hi, hx}));
      end
      held = h.data_valid_out && !h.ready_in;
      hr = h.result;
      ht = h.tag_out;
      hi = h.flag_invalid;
      hx = h.flag_inexact;
      if (h.data_valid_out && h.ready_in) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %h tag %h, required no output", h.result, h.tag_out);
        end else begin
          e = sb.pop_front();
          chk("result", 64'(h.result), 64'(e.res));
          chk("tag", 64'(h.tag_out), 64'(e.tag));
          chk("invalid", 64'(h.flag_invalid), 64'(e.inv));
          chk("inexact", 64'(h.flag_inexact), 64'(e.inx));
          if (e.lc) chk("latency", 64'(ec - e.p), 64'd14);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] dir [11] = '{16'h3C00, 16'h4400, 16'h4880, 16'h4000, 16'h7BFF, 16'hC000,
                              16'h8000, 16'h7C00, 16'h7D00, 16'h7E01, 16'h0001};
    longint unsigned r;
    bit iv, ix, got;
    int p;
    logic [31:0] op32;
    rst = 1'b1;
    h.n = '0;
    h.tag_in = '0;
    h.data_valid_in = 1'b0;
    h32.n = '0;
    h32.tag_in = '0;
    h32.data_valid_in = 1'b0;
    h32.ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_valid", 64'(h.data_valid_out), 64'd0);
    chk("rst_busy", 64'(h.busy), 64'd0);
    chk("rst_result", 64'({h.result, h.tag_out, h.flag_invalid, h.flag_inexact}), 64'd0);
    rst = 1'b0;
    @(negedge clk_in);
    #1;
    chk("rst_ready_out", 64'(h.ready_out), 64'd1);
    started = 1;
    foreach (dir[i]) send(dir[i], 1'b1);
    for (int i = 0; i < 100; i++) send(rnd16(), 1'b1);
    idle();
    drain();
    bp_mode = 1;
    for (int i = 0; i < 20; i++) send(16'h3C00 + 16'(i * 37), 1'b0);
    for (int i = 0; i < 60; i++) send(rnd16(), 1'b0);
    idle();
    drain();
    bp_mode = 0;
    @(negedge clk_in);
    for (int i = 0; i < 5; i++) send(rnd16(), 1'b0);
    idle();
    @(negedge clk_in);
    rst = 1'b1;
    sb.delete();
    @(negedge clk_in);
    #1;
    chk("midrst_valid", 64'(h.data_valid_out), 64'd0);
    chk("midrst_busy", 64'(h.busy), 64'd0);
    chk("midrst_outs", 64'({h.result, h.tag_out, h.flag_invalid, h.flag_inexact}), 64'd0);
    rst = 1'b0;
    @(negedge clk_in);
    #1;
    chk("midrst_ready_out", 64'(h.ready_out), 64'd1);
    repeat (30) @(negedge clk_in);
    for (int i = 0; i < 12; i++) begin
      op32 = (i == 0) ? 32'h40800000 : {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
      ref_sqrt(8, 23, 64'(op32), r, iv, ix);
      @(negedge clk_in);
      h32.n = op32;
      h32.data_valid_in = 1'b1;
      #2;
      p = ec;
      @(negedge clk_in);
      h32.data_valid_in = 1'b0;
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        if (c > 0) @(negedge clk_in);
        #3;
        got = h32.data_valid_out;
      end
      chk("b32_valid", 64'(got), 64'd1);
      if (got) begin
        chk("b32_result", 64'(h32.result), 64'(r[31:0]));
        chk("b32_inexact", 64'(h32.flag_inexact), 64'(ix));
        chk("b32_latency", 64'(ec - p), 64'd27);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_sqrt_pipe.md
# fp_sqrt_pipe

Parametrised, fully pipelined IEEE-754 square root with round-to-nearest-even, special-value handling and valid/ready backpressure. It is the general successor to the fixed binary16 square-root unit: the format is set by exponent/mantissa width parameters. It accepts one operand per cycle and sits in the arithmetic datapath between operand staging and the result writeback/FIFO.

## Interface
- `EXP_W`, default 5: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 10: stored mantissa width (no hidden bit).
- `TAG_W`, default 4: sideband tag carried alongside each operand.
- `clk_in`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `n`  in  1+EXP_W+MAN_W  operand as {sign, exp, man}.
- `tag_in`  in  TAG_W  tag, returned unchanged with the result.
- `data_valid_in`  in  1  operand valid.
- `ready_out`  out  1  pipeline can accept; a transfer occurs when `data_valid_in && ready_out`.
- `result`  out  1+EXP_W+MAN_W  rounded square root.
- `tag_out`  out  TAG_W  tag of `result`.
- `flag_invalid`  out  1  operand was negative nonzero or a signalling NaN.
- `flag_inexact`  out  1  root was rounded (guard or sticky nonzero).
- `data_valid_out`  out  1  result valid.
- `ready_in`  in  1  downstream accepts; the result is consumed when `data_valid_out && ready_in`.
- `busy`  out  1  OR of all stage valid bits.

## Operation
- Stage U (unpack): classify zero/subnormal/normal/inf/NaN. Unbiased E = exp - bias. If E is odd, radicand = {1,man} << 1 and E -= 1; else radicand = {1,man}. Result exponent = (E >>> 1) + bias (arithmetic shift).
- Stages R1..R(MAN_W+2): digit-by-digit binary restoring root, one result bit per stage, producing 1 integer bit, MAN_W fraction bits and 1 guard bit. The remainder is carried through every stage; sticky = (final remainder != 0).
- Stage N (round): increment if guard && (sticky || lsb). A mantissa carry-out renormalises (man = 0, exp += 1). Drop the hidden bit.
- Special cases bypass the arithmetic but travel in the same pipeline slot, so ordering is preserved:
  - +0 → +0; -0 → -0; flags 0.
  - +inf → +inf.
  - Negative nonzero (including -inf) → canonical qNaN {0, all-ones exp, 1, zeros}, invalid = 1.
  - qNaN → canonical qNaN, invalid = 0; sNaN (man MSB 0) → canonical qNaN, invalid = 1.
- A result is never subnormal for any IEEE-shaped parameter set, so no subnormal output path exists.
- Every stage register holds a valid bit; invalid slots carry don't-care data but must not assert any flag at the output.

## Timing
- Latency L = MAN_W + 4 cycles from an accepted input to `data_valid_out` with no stalls (binary16: 14). Throughput is 1 per cycle.
- Global enable en = !data_valid_out || ready_in. When en = 0, every stage holds its contents. `ready_out` = en (combinational).
- Input accepted in the same cycle that `ready_out` is low: the operand is ignored, not captured.
- `result`, `tag_out` and the flags are stable while `data_valid_out && !ready_in`.
- Reset: all valid bits, `data_valid_out`, `busy`, `result`, `tag_out` and the flags go to 0 on the next edge. In-flight operations are discarded. `ready_out` is 1 in the cycle after reset.

## Configuration
- `FP_SQRT_SUBNORMAL_EN` defined: subnormal inputs are normalised in stage U with a leading-zero count and shift (E = 1 - bias - lzc), and the full result is produced. Latency is unchanged because the normalisation is absorbed in stage U.
- Not defined: subnormal inputs are flushed to zero of the same sign (result ±0, flags 0), and the leading-zero logic is omitted.

## Test plan
- Binary16, back-to-back inputs with `ready_in` = 1: 0x3C00→0x3C00, 0x4400→0x4000, 0x4880→0x4200, all with inexact = 0, each 14 cycles after acceptance, tags returned in order.
- Rounding, odd exponent: 0x4000 (2.0) → 0x3DA8 with inexact = 1; 0x7BFF (65504) → 0x5BFF with inexact = 1.
- Specials: 0xC000→0x7E00 invalid = 1; 0x8000→0x8000; 0x7C00→0x7C00; 0x7D00 (sNaN)→0x7E00 invalid = 1; 0x7E01→0x7E00 invalid = 0.
- Subnormal input 0x0001: → 0x0C00 with `FP_SQRT_SUBNORMAL_EN` defined; → 0x0000 without.
- Backpressure: stream 20 operands while toggling `ready_in` low 3 cycles out of every 5 → no result lost or duplicated, and `ready_out` is low exactly when the output is full and stalled.
- Assert `rst` mid-stream with 5 operations in flight → outputs 0 on the next cycle, no stale `data_valid_out` afterwards; `EXP_W`=8 / `MAN_W`=23 smoke test: 0x40800000→0x40000000.
